// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-period table, FSM state encoding, counter width.
package uart_pkg;

  localparam int UART_BAUD_W = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Select-to-cycles-per-bit table, common to transmitter and receiver.
  function automatic logic [15:0] cycles_per_bit(input logic [2:0] sel);
    logic [15:0] n;
    case (sel)
      3'b000:  n = 16'd1042;
      3'b001:  n = 16'd695;
      3'b010:  n = 16'd521;
      3'b011:  n = 16'd261;
      3'b100:  n = 16'd174;
      3'b101:  n = 16'd87;
      3'b110:  n = 16'd79;
      default: n = 16'd39;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the serial line; resets to 1 so the line reads idle.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, centre-sampled, bit period chosen by baud_rate_select.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_W = UART_BAUD_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] baud_rate_select,
  input  logic       Rx_Serial,
  output logic       Rx_Active,
  output logic [7:0] Rx_Byte,
  output logic       Rx_Done,
  output logic       Framing_Error
);

  localparam logic [BAUD_W-1:0] ONE = BAUD_W'(1);

  logic              rx_s;
  uart_state_e       state_q, state_d;
  logic              armed_q, armed_d;
  logic [BAUD_W-1:0] cnt_q, cnt_d;
  logic [BAUD_W-1:0] n_q, n_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        byte_q, byte_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
  logic [BAUD_W-1:0] half;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (Rx_Serial),
    .q_o (rx_s)
  );

  // Start bit is sampled half a bit period after the falling edge.
  assign half = n_q >> 1;

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      n_q     <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: detect start, centre-sample each bit, check stop.
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Arming requires having seen the line high, so a stuck-low
        // line after a framing error cannot retrigger.
        armed_d = armed_q | rx_s;
        if (armed_q && !rx_s) begin
          cnt_d   = '0;
          n_d     = BAUD_W'(cycles_per_bit(baud_rate_select));
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == half - ONE) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            bit_d   = '0;
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      DATA: begin
        if (cnt_q == n_q - ONE) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      STOP: begin
        if (cnt_q == n_q - ONE) begin
          cnt_d   = '0;
          state_d = IDLE;
          armed_d = 1'b0;
          if (rx_s) begin
            byte_d = shift_q;
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Rx_Active     = (state_q != IDLE);
  assign Rx_Byte       = byte_q;
  assign Rx_Done       = done_q;
  assign Framing_Error = ferr_q;

endmodule
